// File: rtl/fifo_drain_pkg.sv
// Shared definitions for the FIFO read-side drain master.
//   drain_state_e : drain FSM encoding (idle / run / flush), 2 bits
//   BufDepth      : local skid-buffer depth, which is also the request credit limit
//   OccW          : width of the buffer occupancy count
package fifo_drain_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2
  } drain_state_e;

  localparam int unsigned BufDepth = 2;
  localparam int unsigned OccW     = 2;

endpackage

// File: rtl/fifo_drain_skid_buf2.sv
// Two-entry valid/ready skid buffer used by fifo_drain.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : write push_data_i at the tail
//   push_data_i   : word to store
//   pop_i         : remove the head word (ignored when empty)
//   occ_o         : number of stored words (0..2)
//   head_o        : registered head word; stable until popped
module fifo_drain_skid_buf2
  import fifo_drain_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [OccW-1:0]   occ_o,
  output logic [DATA_W-1:0] head_o
);

  logic [DATA_W-1:0] data0_q, data0_d;
  logic [DATA_W-1:0] data1_q, data1_d;
  logic [OccW-1:0]   occ_q, occ_d;
  logic              do_pop, do_push;

  assign do_pop  = pop_i && (occ_q != '0);
  // A push into a full, non-popping buffer is dropped; the credit rule upstream prevents it.
  assign do_push = push_i && ((occ_q != OccW'(BufDepth)) || do_pop);

  always_comb begin
    data0_d = data0_q;
    data1_d = data1_q;
    occ_d   = occ_q;
    unique case ({do_push, do_pop})
      2'b10: begin
        if (occ_q == '0) begin
          data0_d = push_data_i;
        end else begin
          data1_d = push_data_i;
        end
        occ_d = occ_q + OccW'(1);
      end
      2'b01: begin
        data0_d = data1_q;
        occ_d   = occ_q - OccW'(1);
      end
      2'b11: begin
        // Occupancy unchanged; the new word lands right behind the surviving head.
        if (occ_q == OccW'(1)) begin
          data0_d = push_data_i;
        end else begin
          data0_d = data1_q;
          data1_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data0_q <= '0;
      data1_q <= '0;
      occ_q   <= '0;
    end else begin
      data0_q <= data0_d;
      data1_q <= data1_d;
      occ_q   <= occ_d;
    end
  end

  assign occ_o  = occ_q;
  assign head_o = data0_q;

endmodule

// File: rtl/fifo_drain.sv
// Read-side master for the cyclic FIFO. Requests words only when the FIFO is
// non-empty and local buffer space is guaranteed, then streams them out as valid/ready.
// Ports:
//   clk, rst                    : clock, asynchronous active-low reset
//   en                          : drain enable
//   fifo_empty, fifo_uf         : FIFO empty flag and underflow pulse
//   read_data, read_data_valid  : FIFO read return, one cycle after read_req
//   read_req                    : combinational read request to the FIFO
//   out_data, out_valid, out_ready : downstream stream
//   busy                        : FSM in run or flush
//   word_cnt                    : delivered words, wrapping
//   err_uf, err_proto           : sticky underflow / unsolicited-data flags
module fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic              fifo_uf,
  input  logic [DATA_W-1:0] read_data,
  input  logic              read_data_valid,
  output logic              read_req,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              err_uf,
  output logic              err_proto
);

  drain_state_e     state_q;
  logic             inflight_q;
  logic [CNT_W-1:0] word_cnt_q;
  logic             err_uf_q, err_proto_q;

  logic [OccW-1:0]  occ;
  logic             pop, push;
  logic [2:0]       credit_used, credit_limit;

  assign out_valid = (occ != '0);
  assign pop       = out_valid && out_ready;
  // Data without an outstanding request is discarded and flagged.
  assign push      = read_data_valid && inflight_q;

  // A pop this cycle frees a slot in time for the word requested now.
  assign credit_used  = 3'(occ) + {2'b00, inflight_q};
  assign credit_limit = 3'(BufDepth) + {2'b00, pop};
  assign read_req     = (state_q == StRun) && !fifo_empty && (credit_used < credit_limit);

  fifo_drain_skid_buf2 #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_i      (push),
    .push_data_i (read_data),
    .pop_i       (pop),
    .occ_o       (occ),
    .head_o      (out_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (en) state_q <= StRun;
        StRun:   if (!en) state_q <= StFlush;
        StFlush: begin
          if (en) begin
            state_q <= StRun;
          end else if ((occ == '0) && !inflight_q) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q  <= 1'b0;
      word_cnt_q  <= '0;
      err_uf_q    <= 1'b0;
      err_proto_q <= 1'b0;
    end else begin
      inflight_q <= read_req;
      if (pop) word_cnt_q <= word_cnt_q + CNT_W'(1);
      if (fifo_uf) err_uf_q <= 1'b1;
      if (read_data_valid && !inflight_q) err_proto_q <= 1'b1;
    end
  end

  assign busy      = (state_q != StIdle);
  assign word_cnt  = word_cnt_q;
  assign err_uf    = err_uf_q;
  assign err_proto = err_proto_q;

endmodule

// File: doc/fifo_drain.md
# fifo_drain

Read-side master for the team's cyclic FIFO: it issues `read_req` only when the FIFO reports non-empty and local space is guaranteed, captures `read_data` on `read_data_valid`, and presents the words as a valid/ready stream to downstream logic. It is the consumer counterpart of the FIFO's write-side producers. It never causes an underflow. It sustains one word per clock when the FIFO is non-empty and downstream is ready.

## Interface
Parameters:
- `DATA_W`, 8, word width; must match the FIFO data width.
- `CNT_W`, 16, width of the delivered-word counter.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  drain enable; while low, no new `read_req` is issued.
- `fifo_empty`  in  1  FIFO empty flag, registered inside the FIFO.
- `fifo_uf`  in  1  FIFO underflow pulse.
- `read_data`  in  DATA_W  FIFO read data.
- `read_data_valid`  in  1  qualifies `read_data`; arrives exactly 1 cycle after an accepted `read_req`.
- `read_req`  out  1  read request to the FIFO; combinational.
- `out_data`  out  DATA_W  stream data; registered buffer head.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  stream ready from downstream.
- `busy`  out  1  high in RUN or FLUSH.
- `word_cnt`  out  CNT_W  words delivered (`out_valid && out_ready`); wraps modulo 2^CNT_W.
- `err_uf`  out  1  sticky; set when `fifo_uf` is seen.
- `err_proto`  out  1  sticky; set when `read_data_valid` arrives with no request in flight.

## Operation
- Internal 2-entry skid buffer with count `occ` (0..2). `inflight` (0/1) marks a request issued last cycle.
- `pop = out_valid && out_ready`.
- `read_req = (state==RUN) && !fifo_empty && (occ + inflight - pop < 2)`. This path is combinational from `out_ready`, `fifo_empty` and `en` (via state).
- `inflight <= read_req` every cycle.
- On `read_data_valid`, the word is pushed at the buffer tail. Push and pop in the same cycle leave `occ` unchanged.
- The credit rule guarantees no overflow. A push while `occ==2` (non-popping) cannot occur.
- `out_valid = (occ != 0)`. `out_data` is held stable while `out_valid && !out_ready`.
- FSM states:
  - IDLE: `read_req`=0. Goes to RUN when `en`=1.
  - RUN: normal draining. Goes to FLUSH when `en`=0.
  - FLUSH: no new requests; the in-flight word is still captured and the buffer drains downstream. Goes to RUN if `en` returns to 1; otherwise to IDLE when `occ==0 && inflight==0`.
- `err_proto`: set on `read_data_valid && !inflight`. The word is discarded.
- `err_uf`: set on `fifo_uf`.
- Both error flags are cleared only by reset.

## Timing
- Reset values: `read_req`=0, `out_valid`=0, `out_data`=0, `busy`=0, `word_cnt`=0, `err_uf`=0, `err_proto`=0, `occ`=0, `inflight`=0, state=IDLE.
- Latency: `read_req` high in cycle n → `read_data_valid` in n+1 → `out_valid` with that word in n+2.
- Sustained throughput is 1 word/cycle with `en`=1, FIFO non-empty and `out_ready`=1.
- Backpressure with `out_ready`=0: at most 2 words are buffered. `read_req` drops once `occ + inflight == 2`.
- `fifo_empty` asserting in cycle n stops `read_req` in cycle n. An in-flight word is still accepted.
- Reset asserted mid-transfer: all state clears immediately. In-flight and buffered words are lost; the FIFO's own reset is expected to coincide.
- `en` toggled low for one cycle in RUN: state passes RUN→FLUSH→RUN. No words are lost or duplicated.

## Structure
- No shared package is required. Put FSM state encoding (IDLE/RUN/FLUSH, 2 bits) in a localparam set in a shared `fifo_pkg` only if other FIFO-side blocks adopt it.
- Natural sub-module is `skid_buf2`: the 2-entry valid/ready buffer with push, pop, `occ`, head data and full handling. `fifo_drain` holds the FSM, credit logic, counter and error flags.

## Test plan
- Basic drain: write 0x11, 0x22, 0x33 into the FIFO, then `en`=1 and `out_ready`=1 → stream delivers 0x11, 0x22, 0x33 in consecutive cycles. The first word appears 2 cycles after the first `read_req`. `word_cnt`=3. FIFO ends empty with `fifo_uf` never set.
- Backpressure: FIFO holds 16 words and `out_ready`=0 for 10 cycles → exactly 2 `read_req` pulses, `occ`=2, `out_data` stable. On release, all 16 words arrive in order with no gaps.
- Empty boundary: FIFO holds 1 word → one `read_req` only. `read_req` stays 0 while `fifo_empty`=1. `err_uf` stays 0.
- Flush: 8 words are present; `en` drops after 3 delivered → at most 2 more words are delivered, then state reaches IDLE and `busy`=0. Re-enabling delivers the rest in order.
- Errors: inject `read_data_valid`=1 with no request → `err_proto`=1 and `word_cnt` unchanged. Pulse `fifo_uf` → `err_uf`=1.
- Reset mid-stream: assert `rst`=0 during a full-throughput run → all outputs take their reset values asynchronously. After release, IDLE → RUN on `en`.
